// File: rtl/multicycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_controller_pkg
// Shared definitions for the multicycle RISC-V controller: FSM state enum,
// ALU select codes, opcode constants, datapath mux encodings and the
// opcode-to-immediate-format helper.
// Build option: CTRL_SHIFT_EN (consumed by alu_decoder) enables SLL/SRL.
// -----------------------------------------------------------------------------
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10
    } state_t;

    // ALU select codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // ALU decoder operating class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // Immediate formats
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Datapath mux encodings
    localparam logic       ADR_PC      = 1'b0;
    localparam logic       ADR_ALUOUT  = 1'b1;
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    // Immediate format implied by the opcode; I-format for everything else
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Maps the controller's ALU class plus funct3/funct7b5 to an ALU select.
// Ports:
//   alu_op      in  2  ADD / SUB / decode-from-funct class
//   funct3      in  3  instruction funct3
//   op5         in  1  opcode bit 5 (R-type vs I-type)
//   funct7b5    in  1  instruction bit 30
//   alu_control out 3  ALU select
//   illegal     out 1  funct3/funct7b5 do not name a supported R/I operation
//                      (independent of alu_op so DECODE can use it early)
// Build option: CTRL_SHIFT_EN enables SLL (funct3 001) and SRL (funct3 101).
// -----------------------------------------------------------------------------
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control,
    output logic       illegal
);

    logic [2:0] funct_ctl_s;
    logic       funct_bad_s;

    // R/I-class funct3 table; SUB only for R-type with bit 30 set
    always_comb begin
        funct_ctl_s = ALU_ADD;
        funct_bad_s = 1'b0;
        case (funct3)
            3'b000:  funct_ctl_s = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_ctl_s = ALU_SLT;
            3'b100:  funct_ctl_s = ALU_XOR;
            3'b110:  funct_ctl_s = ALU_OR;
            3'b111:  funct_ctl_s = ALU_AND;
`ifdef CTRL_SHIFT_EN
            3'b001:  funct_ctl_s = ALU_SLL;
            3'b101: begin
                if (!funct7b5) begin
                    funct_ctl_s = ALU_SRL;
                end else begin
                    funct_bad_s = 1'b1;
                end
            end
`endif
            default: funct_bad_s = 1'b1;
        endcase
    end

    // Final select by operating class
    always_comb begin
        case (alu_op)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_ctl_s;
            default:     alu_control = ALU_ADD;
        endcase
    end

    assign illegal = funct_bad_s;

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Moore FSM controller for a multicycle RV32 subset (lw, sw, R, I, beq, jal).
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   op, funct3, funct7b5, zero      instruction fields and ALU zero flag
//   pc_write, ir_write, mem_write,
//   reg_write                       datapath write strobes (0 while rst_n low)
//   adr_src, alu_src_a, alu_src_b,
//   result_src, imm_src             datapath mux selects
//   alu_control                     ALU select
//   illegal_instr, instr_done       one-cycle status pulses
// Build option: CTRL_SHIFT_EN enables SLL/SRL decode in alu_decoder.
// -----------------------------------------------------------------------------
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal_instr,
    output logic       instr_done
);

    state_t     state_r;
    state_t     next_state_s;
    logic [1:0] alu_op_s;
    logic       dec_illegal_s;
    logic       instr_illegal_s;
    logic       pc_write_s;
    logic       ir_write_s;
    logic       mem_write_s;
    logic       reg_write_s;
    logic       illegal_s;
    logic       done_s;

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op_s),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control),
        .illegal     (dec_illegal_s)
    );

    // Instruction legality: known opcode, and a valid funct for R/I classes
    always_comb begin
        case (op)
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: instr_illegal_s = 1'b0;
            OP_RTYPE, OP_ITYPE:                   instr_illegal_s = dec_illegal_s;
            default:                              instr_illegal_s = 1'b1;
        endcase
    end

    // State register with synchronous reset to FETCH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = FETCH;
        case (state_r)
            FETCH:  next_state_s = DECODE;
            DECODE: begin
                if (instr_illegal_s) begin
                    next_state_s = FETCH;
                end else begin
                    case (op)
                        OP_LOAD, OP_STORE: next_state_s = MEMADR;
                        OP_RTYPE:          next_state_s = EXECUTER;
                        OP_ITYPE:          next_state_s = EXECUTEI;
                        OP_BRANCH:         next_state_s = BEQ;
                        OP_JAL:            next_state_s = JAL;
                        default:           next_state_s = FETCH;
                    endcase
                end
            end
            MEMADR:   next_state_s = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state_s = MEMWB;
            MEMWB:    next_state_s = FETCH;
            MEMWRITE: next_state_s = FETCH;
            EXECUTER: next_state_s = ALUWB;
            EXECUTEI: next_state_s = ALUWB;
            ALUWB:    next_state_s = FETCH;
            BEQ:      next_state_s = FETCH;
            JAL:      next_state_s = ALUWB;
            default:  next_state_s = FETCH;
        endcase
    end

    // Per-state output decode; unlisted outputs stay at their zero default
    always_comb begin
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        illegal_s   = 1'b0;
        done_s      = 1'b0;
        adr_src     = ADR_PC;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        result_src  = RES_ALUOUT;
        alu_op_s    = ALUOP_ADD;
        case (state_r)
            FETCH: begin
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                illegal_s = instr_illegal_s;
            end
            MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            MEMREAD: adr_src = ADR_ALUOUT;
            MEMWB: begin
                result_src  = RES_MEMDATA;
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            MEMWRITE: begin
                adr_src     = ADR_ALUOUT;
                mem_write_s = 1'b1;
                done_s      = 1'b1;
            end
            EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_op_s  = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op_s  = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
                done_s      = 1'b1;
            end
            BEQ: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_op_s   = ALUOP_SUB;
                pc_write_s = zero;
                done_s     = 1'b1;
            end
            JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write_s = 1'b1;
            end
            default: alu_op_s = ALUOP_ADD;
        endcase
    end

    // Strobes and pulses are suppressed for as long as reset is held
    assign pc_write      = pc_write_s  & rst_n;
    assign ir_write      = ir_write_s  & rst_n;
    assign mem_write     = mem_write_s & rst_n;
    assign reg_write     = reg_write_s & rst_n;
    assign illegal_instr = illegal_s   & rst_n;
    assign instr_done    = done_s      & rst_n;
    assign imm_src       = imm_src_of(op);

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Instruction-level reference model: each instruction class has a fixed
// timeline of control vectors; the bench holds an instruction's fields for
// its whole duration and compares every cycle at the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_write;
        logic       reg_write;
        logic       adr_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] res;
        logic [1:0] imm;
        logic [2:0] alu;
        logic       ill;
        logic       done;
    } ctl_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;
    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;
`ifdef CTRL_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       pc_write, ir_write, mem_write, reg_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0] alu_control;
    logic       illegal_instr, instr_done;

    ctl_t  dut_v;
    ctl_t  exp_v;
    ctl_t  cap [0:7];
    logic  exp_valid = 1'b0;
    int    exp_k = 0;
    string tag = "reset";
    int    checks = 0;
    int    errors = 0;
    int    lens [0:6] = '{5, 4, 4, 4, 3, 4, 2};

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write),
        .reg_write(reg_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src),
        .alu_control(alu_control), .illegal_instr(illegal_instr), .instr_done(instr_done)
    );

    always #5 clk = ~clk;

    assign dut_v = {pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a,
                    alu_src_b, result_src, imm_src, alu_control, illegal_instr, instr_done};

    // {legal, alu select} for an R/I instruction
    function automatic logic [3:0] alu_ref(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return {1'b1, (o[5] && f7) ? 3'b001 : 3'b000};
            3'd2:    return 4'b1101;
            3'd4:    return 4'b1100;
            3'd6:    return 4'b1011;
            3'd7:    return 4'b1010;
            3'd1:    return SHIFT_EN ? 4'b1110 : 4'b0000;
            3'd5:    return (SHIFT_EN && !f7) ? 4'b1111 : 4'b0000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int kind_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        logic [3:0] a;
        a = alu_ref(o, f3, f7);
        if (o == LW) return K_LW;
        if (o == SW) return K_SW;
        if (o == BR) return K_BEQ;
        if (o == JL) return K_JAL;
        if (o == RT) return a[3] ? K_R : K_ILL;
        if (o == IT) return a[3] ? K_I : K_ILL;
        return K_ILL;
    endfunction

    // Expected controls in cycle k of an instruction (k = 0 is its fetch)
    function automatic ctl_t model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                   input logic z, input int k, input logic rst_low);
        ctl_t c;
        int kd;
        logic [3:0] a;
        kd = kind_of(o, f3, f7);
        a  = alu_ref(o, f3, f7);
        c  = '0;
        c.imm = (o == SW) ? 2'b01 : (o == BR) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
        if (k == 0) begin
            c.ir_write = 1'b1; c.pc_write = 1'b1; c.src_b = 2'b10; c.res = 2'b10;
        end else if (k == 1) begin
            c.src_a = 2'b01; c.src_b = 2'b01; c.ill = (kd == K_ILL);
        end else if (kd == K_LW || kd == K_SW) begin
            if (k == 2) begin c.src_a = 2'b10; c.src_b = 2'b01; end
            else if (k == 3) begin
                c.adr_src = 1'b1;
                c.mem_write = (kd == K_SW); c.done = (kd == K_SW);
            end else begin
                c.res = 2'b01; c.reg_write = 1'b1; c.done = 1'b1;
            end
        end else if (kd == K_R || kd == K_I) begin
            if (k == 2) begin
                c.src_a = 2'b10; c.src_b = (kd == K_R) ? 2'b00 : 2'b01; c.alu = a[2:0];
            end else begin
                c.reg_write = 1'b1; c.done = 1'b1;
            end
        end else if (kd == K_BEQ) begin
            c.src_a = 2'b10; c.alu = 3'b001; c.pc_write = z; c.done = 1'b1;
        end else if (kd == K_JAL) begin
            if (k == 2) begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_write = 1'b1; end
            else begin c.reg_write = 1'b1; c.done = 1'b1; end
        end
        if (rst_low) begin
            c.pc_write = 1'b0; c.ir_write = 1'b0; c.mem_write = 1'b0;
            c.reg_write = 1'b0; c.ill = 1'b0; c.done = 1'b0;
        end
        return c;
    endfunction

    // Single compare process: every cycle the model holds an expectation
    always @(negedge clk) begin
        if (exp_valid) begin
            checks = checks + 1;
            if (dut_v !== exp_v) begin
                errors = errors + 1;
                $display("FAIL %s cycle %0d: got %b expected %b", tag, exp_k, dut_v, exp_v);
            end
            if (exp_k < 8) cap[exp_k] = dut_v;
        end
    end

    task automatic lit(input string name, input logic [2:0] act, input logic [2:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Called one step after the edge that enters the instruction's fetch
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input string t);
        int n;
        n = lens[kind_of(o, f3, f7)];
        op = o; funct3 = f3; funct7b5 = f7; zero = z; tag = t;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            exp_k = k; exp_v = model(o, f3, f7, z, k, 1'b0); exp_valid = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [6:0] ro;
        logic [6:0] ops [0:6];
        int sel;
        ops = '{LW, SW, RT, IT, BR, JL, 7'b1111111};

        // Reset held for three edges
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            tag = "reset"; exp_k = 0; exp_valid = 1'b1;
            exp_v = model(op, funct3, funct7b5, zero, 0, 1'b1);
            if (i == 1) begin
                lit("reset_ir_write", {2'b00, ir_write}, 3'd0);
                lit("reset_src_b", {1'b0, alu_src_b}, 3'd2);
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b1;

        run_instr(RT, 3'b000, 1'b0, 1'b0, "add");
        lit("add_alu", cap[2].alu, 3'b000);
        lit("add_done_early", {2'b00, cap[2].done}, 3'd0);
        lit("add_reg_write", {2'b00, cap[3].reg_write}, 3'd1);
        lit("add_done", {2'b00, cap[3].done}, 3'd1);

        run_instr(RT, 3'b000, 1'b1, 1'b0, "sub");
        lit("sub_alu", cap[2].alu, 3'b001);

        run_instr(LW, 3'b010, 1'b0, 1'b0, "lw");
        lit("lw_adr_src", {2'b00, cap[3].adr_src}, 3'd1);
        lit("lw_result_src", {1'b0, cap[4].res}, 3'd1);
        lit("lw_reg_write", {2'b00, cap[4].reg_write}, 3'd1);

        run_instr(SW, 3'b010, 1'b0, 1'b0, "sw");
        lit("sw_mem_write", {2'b00, cap[3].mem_write}, 3'd1);
        lit("sw_mem_write_count", {1'b0, 2'(cap[0].mem_write) + 2'(cap[1].mem_write)
                                         + 2'(cap[2].mem_write)}, 3'd0);

        run_instr(BR, 3'b000, 1'b0, 1'b1, "beq_taken");
        lit("beq_taken_pc_write", {2'b00, cap[2].pc_write}, 3'd1);
        lit("beq_taken_alu", cap[2].alu, 3'b001);
        run_instr(BR, 3'b000, 1'b0, 1'b0, "beq_not_taken");
        lit("beq_nt_pc_write", {2'b00, cap[2].pc_write}, 3'd0);
        lit("beq_nt_alu", cap[2].alu, 3'b001);

        run_instr(JL, 3'b000, 1'b0, 1'b0, "jal");
        lit("jal_pc_write", {2'b00, cap[2].pc_write}, 3'd1);
        lit("jal_reg_write", {2'b00, cap[3].reg_write}, 3'd1);

        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, "illegal_op");
        lit("illegal_pulse", {2'b00, cap[1].ill}, 3'd1);
        lit("illegal_writes", {1'b0, cap[1].reg_write, cap[1].mem_write}, 3'd0);

        run_instr(IT, 3'b001, 1'b0, 1'b0, "slli");
`ifdef CTRL_SHIFT_EN
        lit("slli_alu", cap[2].alu, 3'b110);
        lit("slli_reg_write", {2'b00, cap[3].reg_write}, 3'd1);
`else
        lit("slli_illegal", {2'b00, cap[1].ill}, 3'd1);
`endif
        run_instr(IT, 3'b101, 1'b1, 1'b0, "srai");
        lit("srai_illegal", {2'b00, cap[1].ill}, 3'd1);

        // Reset asserted while a load is in MEMREAD
        op = LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0; tag = "lw_rst";
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            if (k == 3) rst_n = 1'b0;
            exp_k = k; exp_v = model(LW, 3'b010, 1'b0, 1'b0, k, (k == 3)); exp_valid = 1'b1;
        end
        @(posedge clk); #1;
        exp_k = 0; exp_v = model(LW, 3'b010, 1'b0, 1'b0, 0, 1'b1);
        lit("rst_mid_src_b", {1'b0, alu_src_b}, 3'd2);
        lit("rst_mid_reg_write", {2'b00, reg_write}, 3'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_instr(RT, 3'b111, 1'b0, 1'b0, "and_after_rst");

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 7));
            ro  = (sel == 7) ? 7'($urandom) : ops[sel];
            run_instr(ro, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), "random");
        end

        exp_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 No parameters; ALU select encoding fixed: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT, 110 SLL, 111 SRL.
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 op  input  7  instruction opcode from the instruction register.
REQ-006 funct3  input  3  instruction funct3.
REQ-007 funct7b5  input  1  instruction bit 30.
REQ-008 zero  input  1  ALU zero flag.
REQ-009 pc_write, ir_write, mem_write, reg_write  output  1 each  datapath write strobes.
REQ-010 adr_src  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-011 alu_src_a  output  2  00 = PC, 01 = oldPC, 10 = rs1.
REQ-012 alu_src_b  output  2  00 = rs2, 01 = immediate, 10 = constant 4.
REQ-013 result_src  output  2  00 = ALU out register, 01 = memory data, 10 = live ALU result.
REQ-014 imm_src  output  2  00 = I, 01 = S, 10 = B, 11 = J.
REQ-015 alu_control  output  3  ALU select per REQ-001.
REQ-016 illegal_instr, instr_done  output  1 each  single-cycle status pulses.

Function
REQ-017 The FSM SHALL use these states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-018 All outputs SHALL be combinational (Moore) from the state, plus op/funct/zero where stated; an output not listed for a state SHALL be 0.
REQ-019 FETCH: adr_src 0, ir_write 1, alu_src_a 00, alu_src_b 10, ADD, result_src 10, pc_write 1; next state DECODE.
REQ-020 DECODE: alu_src_a 01, alu_src_b 01, ADD; next state by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1100011 -> BEQ, 1101111 -> JAL.
REQ-021 MEMADR: alu_src_a 10, alu_src_b 01, ADD; next state MEMREAD if op[5]=0, otherwise MEMWRITE.
REQ-022 MEMREAD: adr_src 1, result_src 00; next state MEMWB.
REQ-023 MEMWB: result_src 01, reg_write 1; next state FETCH.
REQ-024 MEMWRITE: adr_src 1, result_src 00, mem_write 1; next state FETCH.
REQ-025 EXECUTER (alu_src_b 00) and EXECUTEI (alu_src_b 01): alu_src_a 10, alu_control from the ALU decoder; next state ALUWB.
REQ-026 ALUWB: result_src 00, reg_write 1; next state FETCH.
REQ-027 BEQ: alu_src_a 10, alu_src_b 00, SUB, result_src 00, pc_write = zero; next state FETCH.
REQ-028 JAL: alu_src_a 01, alu_src_b 10, ADD, result_src 00, pc_write 1; next state ALUWB.
REQ-029 ALU decoder, R/I class funct3 mapping: 000 -> SUB if op[5] and funct7b5, else ADD; 010 -> SLT; 100 -> XOR; 110 -> OR; 111 -> AND; 001 -> SLL; 101 -> SRL when funct7b5 = 0.
REQ-030 Unlisted funct3 values, funct3 101 with funct7b5 = 1, and unlisted opcodes SHALL be illegal.
REQ-031 imm_src SHALL be derived from op in every state: S for 0100011, B for 1100011, J for 1101111, I otherwise.
REQ-032 On an illegal instruction, DECODE SHALL assert illegal_instr for exactly one cycle, SHALL go to FETCH, and no write strobe may be asserted for that instruction.
REQ-033 instr_done SHALL pulse in the final state of each instruction: MEMWB, MEMWRITE, ALUWB, BEQ.
REQ-034 Cycle counts from FETCH to FETCH SHALL be: lw 5, sw 4, R 4, I 4, beq 3, jal 4, illegal 2.

Reset
REQ-035 While rst_n = 0 at a clock edge, state SHALL become FETCH.
REQ-036 While rst_n is low, all write strobes, illegal_instr and instr_done SHALL be forced to 0.
REQ-037 Reset asserted mid-instruction SHALL abandon that instruction; the first edge with rst_n = 1 starts a FETCH.

Configuration
REQ-038 Macro CTRL_SHIFT_EN: when defined, SLL/SRL decode per REQ-029.
REQ-039 When CTRL_SHIFT_EN is undefined, funct3 001/101 SHALL be illegal per REQ-032.

Structure
REQ-040 A shared package SHALL hold the state enum, the ALU select constants, the opcode constants, and the imm_src/src-mux encodings.
REQ-041 The ALU decoder SHALL be a sub-module named alu_decoder (inputs alu_op[1:0], funct3, op5, funct7b5; outputs alu_control, illegal).

Verification
REQ-042 add x3,x1,x2 (op 0110011, f3 000, f7b5 0) -> FETCH, DECODE, EXECUTER (alu_control 000), ALUWB (reg_write 1), then FETCH; instr_done on cycle 4.
REQ-043 lw -> 5-cycle sequence; MEMREAD adr_src 1; MEMWB result_src 01, reg_write 1; sw -> mem_write 1 for exactly one cycle in MEMWRITE.
REQ-044 beq with zero 1 -> pc_write 1 in BEQ; with zero 0 -> pc_write 0; alu_control 001 in both cases.
REQ-045 op 1111111 -> illegal_instr for one cycle in DECODE, next state FETCH, no reg_write/mem_write asserted.
REQ-046 slli (f3 001), run with and without CTRL_SHIFT_EN -> alu_control 110 with ALUWB, versus illegal_instr pulse; srai (f3 101, f7b5 1) -> illegal in both builds.
REQ-047 rst_n driven low during MEMREAD -> state FETCH at the next edge, strobes 0 while low, clean FETCH once released.
